// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: rebuilds R/G/B from sector/fraction hue, saturation and value.
// Four register stages (S1..S4); ce freezes the whole pipe, reset clears it.
module hsv_to_rgb #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         valid_in,
    input  logic [2:0]   sector,
    input  logic [W-1:0] frac,
    input  logic [W-1:0] sat,
    input  logic [W-1:0] val,
    output logic [W-1:0] red,
    output logic [W-1:0] green,
    output logic [W-1:0] blue,
    output logic         valid_out,
    output logic         illegal
);

    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] FRAC_MAX = {W{1'b1}};

    // Only the upper halves of the S1 products are ever consumed, so only
    // those are stored; downstream values are identical to full-width storage.
    logic         s1_valid_q;
    logic [2:0]   s1_sector_q;
    logic [W-1:0] s1_val_q, s1_a_hi_q, s1_b_hi_q, s1_c_hi_q;
    logic [W-1:0] s1_a_hi_d, s1_b_hi_d, s1_c_hi_d;

    logic         s2_valid_q;
    logic [2:0]   s2_sector_q;
    logic [W-1:0] s2_val_q, s2_p_q, s2_qa_q, s2_tb_q;
    logic [W-1:0] s2_p_d;

    logic         s3_valid_q;
    logic [2:0]   s3_sector_q;
    logic [W-1:0] s3_val_q, s3_p_q, s3_q_q, s3_t_q;
    logic [W-1:0] s3_q_d, s3_t_d;

    logic [W-1:0] red_d, green_d, blue_d;
    logic         illegal_d;

    // S1 products, truncated to their integer part (floor of /2^W)
    always_comb begin
        s1_a_hi_d = W'((PW'(sat) * PW'(frac)) >> W);
        s1_b_hi_d = W'((PW'(sat) * PW'(FRAC_MAX - frac)) >> W);
        s1_c_hi_d = W'((PW'(val) * PW'(sat)) >> W);
    end

    // S2: p = val - val*sat; cannot underflow since c_hi <= val
    always_comb begin
        s2_p_d = s1_val_q - s1_c_hi_q;
    end

    // S3: q and t scale val by the sector-relative fractions
    always_comb begin
        s3_q_d = s2_val_q - W'((PW'(s2_val_q) * PW'(s2_qa_q)) >> W);
        s3_t_d = s2_val_q - W'((PW'(s2_val_q) * PW'(s2_tb_q)) >> W);
    end

    // S4 output mux by hue sector; illegal sectors render as grey at val
    always_comb begin
        red_d     = s3_val_q;
        green_d   = s3_val_q;
        blue_d    = s3_val_q;
        illegal_d = 1'b0;
        case (s3_sector_q)
            3'd0: begin red_d = s3_val_q; green_d = s3_t_q;   blue_d = s3_p_q;   end
            3'd1: begin red_d = s3_q_q;   green_d = s3_val_q; blue_d = s3_p_q;   end
            3'd2: begin red_d = s3_p_q;   green_d = s3_val_q; blue_d = s3_t_q;   end
            3'd3: begin red_d = s3_p_q;   green_d = s3_q_q;   blue_d = s3_val_q; end
            3'd4: begin red_d = s3_t_q;   green_d = s3_p_q;   blue_d = s3_val_q; end
            3'd5: begin red_d = s3_val_q; green_d = s3_p_q;   blue_d = s3_q_q;   end
            default: illegal_d = 1'b1;
        endcase
    end

    // Pipeline registers: reset clears everything, ce gates every update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sector_q <= '0;
            s1_val_q    <= '0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            s1_c_hi_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sector_q <= '0;
            s2_val_q    <= '0;
            s2_p_q      <= '0;
            s2_qa_q     <= '0;
            s2_tb_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_sector_q <= '0;
            s3_val_q    <= '0;
            s3_p_q      <= '0;
            s3_q_q      <= '0;
            s3_t_q      <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            valid_out   <= 1'b0;
            illegal     <= 1'b0;
        end else if (ce) begin
            s1_valid_q  <= valid_in;
            s1_sector_q <= sector;
            s1_val_q    <= val;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            s1_c_hi_q   <= s1_c_hi_d;
            s2_valid_q  <= s1_valid_q;
            s2_sector_q <= s1_sector_q;
            s2_val_q    <= s1_val_q;
            s2_p_q      <= s2_p_d;
            s2_qa_q     <= s1_a_hi_q;
            s2_tb_q     <= s1_b_hi_q;
            s3_valid_q  <= s2_valid_q;
            s3_sector_q <= s2_sector_q;
            s3_val_q    <= s2_val_q;
            s3_p_q      <= s2_p_q;
            s3_q_q      <= s3_q_d;
            s3_t_q      <= s3_t_d;
            red         <= red_d;
            green       <= green_d;
            blue        <= blue_d;
            valid_out   <= s3_valid_q;
            illegal     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: driver pushes expected pixels with the
// ce-edge index they are due on; the monitor checks every output edge.
module tb_hsv_to_rgb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] sector = '0;
    logic [9:0] frac = '0;
    logic [9:0] sat = '0;
    logic [9:0] val = '0;
    logic [9:0] red, green, blue;
    logic       valid_out, illegal;

    typedef struct {
        int r;
        int g;
        int b;
        int il;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    hsv_to_rgb #(.W(10)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .valid_in(valid_in),
        .sector(sector), .frac(frac), .sat(sat), .val(val),
        .red(red), .green(green), .blue(blue),
        .valid_out(valid_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: HSV sector reconstruction with integer floor division
    function automatic exp_t model(input int sc, input int f, input int s, input int v);
        exp_t e;
        int p, q, t, qa, tb;
        p  = v - (v * s) / 1024;
        qa = (s * f) / 1024;
        tb = (s * (1023 - f)) / 1024;
        q  = v - (v * qa) / 1024;
        t  = v - (v * tb) / 1024;
        e.il = 0;
        e.due = 0;
        case (sc)
            0: begin e.r = v; e.g = t; e.b = p; end
            1: begin e.r = q; e.g = v; e.b = p; end
            2: begin e.r = p; e.g = v; e.b = t; end
            3: begin e.r = p; e.g = q; e.b = v; end
            4: begin e.r = t; e.g = p; e.b = v; end
            5: begin e.r = v; e.g = p; e.b = q; end
            default: begin e.r = v; e.g = v; e.b = v; e.il = 1; end
        endcase
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; a sampled pixel is due 4 ce-edges after this one
    task automatic cyc(input logic c, input logic r, input logic vi,
                       input int sc, input int f, input int s, input int v);
        exp_t e;
        @(negedge clk);
        ce = c; rst_n = r; valid_in = vi;
        sector = 3'(sc); frac = 10'(f); sat = 10'(s); val = 10'(v);
        if (c && r && vi) begin
            e = model(sc, f, s, v);
            e.due = edge_cnt + 4;
            sb.push_back(e);
        end
    endtask

    // Directed pixel with hand-derived expected colour
    task automatic send_k(input int sc, input int f, input int s, input int v,
                          input int er, input int eg, input int eb, input int eil);
        exp_t e;
        @(negedge clk);
        ce = 1'b1; rst_n = 1'b1; valid_in = 1'b1;
        sector = 3'(sc); frac = 10'(f); sat = 10'(s); val = 10'(v);
        e.r = er; e.g = eg; e.b = eb; e.il = eil;
        e.due = edge_cnt + 4;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    // Monitor: checks reset clearing, valid timing, data and stall freeze
    initial begin
        logic cs, rs, last_valid;
        exp_t last_e, e;
        last_valid = 1'b0;
        last_e = '{0, 0, 0, 0, 0};
        forever begin
            @(posedge clk);
            cs = ce; rs = rst_n;
            #1;
            if (!rs) begin
                sb.delete();
                last_valid = 1'b0;
                check("reset_valid_out", int'(valid_out), 0);
                check("reset_rgb", int'(red) + int'(green) + int'(blue), 0);
                check("reset_illegal", int'(illegal), 0);
            end else if (cs) begin
                edge_cnt++;
                while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                    e = sb.pop_front();
                    check("missing_pixel_due", edge_cnt, e.due);
                end
                if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                    e = sb.pop_front();
                    check("valid_out", int'(valid_out), 1);
                    check("red", int'(red), e.r);
                    check("green", int'(green), e.g);
                    check("blue", int'(blue), e.b);
                    check("illegal", int'(illegal), e.il);
                    last_valid = 1'b1;
                    last_e = e;
                end else begin
                    check("valid_out_idle", int'(valid_out), 0);
                    last_valid = 1'b0;
                end
            end else begin
                check("stall_valid_hold", int'(valid_out), int'(last_valid));
                if (last_valid) begin
                    check("stall_red_hold", int'(red), last_e.r);
                    check("stall_green_hold", int'(green), last_e.g);
                    check("stall_blue_hold", int'(blue), last_e.b);
                    check("stall_illegal_hold", int'(illegal), last_e.il);
                end
            end
        end
    end

    initial begin
        int sc, f, s, v;
        logic c, vi;
        // Reset
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        idle(2);

        // Directed vectors
        send_k(0, 256, 512, 800, 800, 501, 400, 0);
        idle(5);
        send_k(3, 256, 512, 800, 400, 700, 800, 0);
        send_k(7, 256, 512, 800, 800, 800, 800, 1);
        send_k(6, 100, 900, 5, 5, 5, 5, 1);
        send_k(1, 0, 1023, 1023, 1023, 1023, 1, 0);
        for (int k = 0; k < 6; k++) send_k(k, 333, 0, 37, 37, 37, 37, 0);
        send_k(2, 700, 800, 0, 0, 0, 0, 0);
        idle(5);

        // Stream of 8 with a 3-cycle stall in the middle
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, k, 100 * k + 50, 300 + k, 900 - k);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 5, 1, 1, 1);
        for (int k = 4; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, k % 6, 100 * k + 50, 300 + k, 900 - k);
        idle(6);

        // Reset with 3 pixels in flight, then a fresh pixel
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1, k + 2, 600, 1000, 999);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        idle(3);
        send_k(0, 256, 512, 800, 800, 501, 400, 0);
        idle(6);

        // Randomized traffic with random bubbles and stalls
        for (int n = 0; n < 10000; ) begin
            c  = ($urandom_range(0, 9) != 0);
            vi = ($urandom_range(0, 4) != 0);
            sc = $urandom_range(0, 7);
            f  = $urandom_range(0, 1023);
            s  = $urandom_range(0, 1023);
            v  = $urandom_range(0, 1023);
            cyc(c, 1'b1, vi, sc, f, s, v);
            if (c && vi) n++;
        end
        idle(8);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
